intrusion_sequencer: RTL and testbench
======================================

Name: intrusion_sequencer

Overview:
Arming/alarm controller that sequences the ultrasonic range sensor and drives the alarm tone generator. It schedules periodic measurement requests to the sensor controller and filters returned distances with a consecutive-hit counter. It runs the arm, exit-delay, entry-delay and alarm state machine and gates the sound enable to the alarm controller. It sits between the sensor controller and the alarm controller, clocked by the divided trigger clock.

Parameters:
DIST_W, 8, width of the Distance input (cm)
THRESH, 30, intrusion threshold; a hit is a valid reading with 0 < Distance < THRESH
HITS, 3, consecutive hits required to declare intrusion
MEAS_PERIOD, 6000, CLK cycles between measurement requests; also the echo timeout
EXIT_TICKS, 20000, exit-delay length in CLK cycles
ENTRY_TICKS, 20000, entry-delay length in CLK cycles
ALARM_TICKS, 100000, alarm sounding length in CLK cycles

Ports:
CLK  in  1  trigger-domain clock
RST  in  1  reset
Arm  in  1  one-cycle arm request
Disarm  in  1  one-cycle disarm request
Meas_Done  in  1  one-cycle pulse; Distance is valid this cycle
Distance  in  DIST_W  measured distance in cm; 0 means no echo
Meas_Start  out  1  one-cycle measurement request to the sensor controller
Sound_En  out  1  enables the alarm tone stream
Armed  out  1  high in ARMED, ENTRY or ALARM
State  out  3  current state code

Behaviour:
- Interface: one clock, CLK; reset RST is synchronous and active-high.
- Reset values: State=DISARMED(0), Meas_Start=0, Sound_En=0, Armed=0. All counters and the hit counter are 0, and the outstanding flag is clear.
- State codes: DISARMED=0, EXIT=1, ARMED=2, ENTRY=3, ALARM=4. Codes 5-7 are illegal and go to DISARMED on the next cycle.
- All outputs are registered. A state change is visible one cycle after the causing input.
- Disarm has top priority. From any state, Disarm=1 forces DISARMED on the next cycle and clears all counters. When Arm and Disarm are both asserted, Disarm wins.
- DISARMED:
  - Arm=1 -> EXIT with the delay counter loaded to 0.
  - No measurements are issued.
- EXIT:
  - Measurements run, but hits are ignored and the hit counter is held at 0.
  - After EXIT_TICKS cycles -> ARMED.
  - Arm in this state is ignored.
- ARMED: when the hit counter reaches HITS -> ENTRY.
- ENTRY:
  - After ENTRY_TICKS cycles -> ALARM.
  - Further hits are ignored.
- ALARM:
  - Sound_En=1 for exactly ALARM_TICKS cycles, then -> ARMED with the hit counter cleared.
  - Sound_En=0 in every other state unless the optional feature is compiled in.
- Measurement scheduler (active in every state except DISARMED):
  - Period counter counts 0..MEAS_PERIOD-1 and wraps.
  - On wrap, if no measurement is outstanding, Meas_Start=1 for one cycle and the outstanding flag is set.
  - Meas_Done clears the flag.
  - If the period counter wraps again with the flag still set, this is a timeout: it counts as a miss, the flag is cleared, and no Meas_Start is issued that cycle.
  - Meas_Done while not outstanding is ignored.
  - Entering DISARMED resets the period counter to 0.
- Hit filter:
  - On an accepted Meas_Done, a hit increments the counter, saturating at HITS.
  - A miss clears the counter. A miss is Distance=0, Distance >= THRESH, or a timeout.
  - Distance == THRESH is a miss.
- Counter widths are $clog2 of the respective parameter plus 1. No wrap is allowed inside a delay.

Optional Feature:
SEC_DELAY_CHIRP_EN:
- Defined: during EXIT and ENTRY, Sound_En toggles every 1024 CLK cycles, starting at 1 on state entry, to give a warning chirp.
- Undefined: Sound_En is 0 in EXIT and ENTRY.
- ALARM behaviour is identical in both builds.

Decomposition:
- Package sec_pkg holds:
  - sec_state_t enum with the five state codes;
  - the default THRESH/HITS constants;
  - the chirp half-period constant, 1024.
- One sub-module, meas_scheduler, contains the period counter, outstanding flag, timeout detection and Meas_Start generation.
- meas_scheduler outputs an accepted-result pulse plus a hit/miss flag.

Test Plan:
All scenarios use test parameters MEAS_PERIOD=16, EXIT_TICKS=40, ENTRY_TICKS=40, ALARM_TICKS=64, HITS=3, THRESH=30.
1. Reset then Arm pulse -> State=1 next cycle. Meas_Start pulses every 16 cycles. State=2 exactly 40 cycles after entering EXIT. Armed=1.
2. ARMED, three consecutive Meas_Done with Distance=10 -> State=3 the cycle after the third. Then 40 cycles later State=4, Sound_En=1 for 64 cycles, then State=2 and Sound_En=0.
3. ARMED, Distance sequence 10, 10, 0, 10, 10, 30 -> never leaves State=2. The hit count reaches at most 2.
4. ARMED, withhold Meas_Done -> no second Meas_Start at the next wrap (timeout counted as a miss). Meas_Start resumes on the following wrap. The hit counter is 0.
5. ALARM in progress, Arm and Disarm asserted together -> State=0 next cycle, Sound_En=0, Meas_Start stays 0 thereafter.
6. RST asserted mid-ENTRY -> next cycle all outputs are at reset values. With SEC_DELAY_CHIRP_EN defined, Sound_En=1 on the first EXIT cycle and toggles after 1024 cycles.

Source files
------------

// File: rtl/sec_pkg.sv
// Shared types and constants for the intrusion sequencer.
//   sec_state_t : arming/alarm state codes (3-bit, codes 5-7 illegal)
//   DEF_THRESH  : default intrusion threshold in cm
//   DEF_HITS    : default consecutive hits needed to declare intrusion
//   CHIRP_HALF  : warning-chirp half period in CLK cycles
package sec_pkg;

  typedef enum logic [2:0] {
    ST_DISARMED = 3'd0,
    ST_EXIT     = 3'd1,
    ST_ARMED    = 3'd2,
    ST_ENTRY    = 3'd3,
    ST_ALARM    = 3'd4
  } sec_state_t;

  localparam int unsigned DEF_THRESH = 30;
  localparam int unsigned DEF_HITS   = 3;
  localparam int unsigned CHIRP_HALF = 1024;

  // Exit and entry delays share the warning-chirp behaviour.
  function automatic logic is_delay_state(input sec_state_t s);
    return (s == ST_EXIT) || (s == ST_ENTRY);
  endfunction

endpackage

// File: rtl/meas_scheduler.sv
// Periodic measurement scheduler for the ultrasonic sensor controller.
// Issues a one-cycle request every MEAS_PERIOD cycles, tracks whether a
// request is outstanding, and turns each returned reading or echo timeout
// into a one-cycle result with a hit/miss classification.
// Ports:
//   CLK, RST    : clock, synchronous active-high reset
//   en          : scheduler enable; low holds everything cleared
//   meas_done   : sensor result strobe, distance valid this cycle
//   distance    : measured distance in cm, 0 = no echo
//   meas_start  : registered one-cycle measurement request
//   res_valid   : combinational accepted-result pulse (reading or timeout)
//   res_hit     : qualifies res_valid; 1 = 0 < distance < THRESH
module meas_scheduler
  import sec_pkg::*;
#(
  parameter int unsigned DIST_W      = 8,
  parameter int unsigned THRESH      = DEF_THRESH,
  parameter int unsigned MEAS_PERIOD = 6000
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              en,
  input  logic              meas_done,
  input  logic [DIST_W-1:0] distance,
  output logic              meas_start,
  output logic              res_valid,
  output logic              res_hit
);

  localparam int unsigned PER_W = $clog2(MEAS_PERIOD) + 1;
  localparam logic [PER_W-1:0] PER_LAST = PER_W'(MEAS_PERIOD - 1);

  logic [PER_W-1:0] per_cnt;
  logic             outstanding;
  logic             wrap;
  logic             done_acc;
  logic             timeout;
  logic             issue;

  assign wrap     = (per_cnt == PER_LAST);
  // Strobes arriving with no request in flight are stale and dropped.
  assign done_acc = meas_done & outstanding;
  // A reading landing on the wrap cycle still counts as a reading.
  assign timeout  = wrap & outstanding & ~meas_done;
  // A new request goes out on wrap unless the previous one timed out.
  assign issue    = wrap & ~timeout;

  assign res_valid = done_acc | timeout;
  assign res_hit   = done_acc && (distance != '0) && (32'(distance) < THRESH);

  // NOTE: state registers use non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RST || !en) begin
      per_cnt     <= '0;
      outstanding <= 1'b0;
      meas_start  <= 1'b0;
    end else begin
      per_cnt    <= wrap ? '0 : per_cnt + PER_W'(1);
      meas_start <= issue;
      if (issue)
        outstanding <= 1'b1;
      else if (res_valid)
        outstanding <= 1'b0;
    end
  end

endmodule

// File: rtl/intrusion_sequencer.sv
// Arming/alarm controller: runs the DISARMED/EXIT/ARMED/ENTRY/ALARM state
// machine, schedules sensor measurements through meas_scheduler, filters
// readings with a consecutive-hit counter and gates the alarm tone enable.
// Optional build macro SEC_DELAY_CHIRP_EN: when defined, Sound_En toggles
// every CHIRP_HALF cycles during EXIT and ENTRY, starting high on entry.
// Ports:
//   CLK, RST   : trigger-domain clock, synchronous active-high reset
//   Arm        : one-cycle arm request
//   Disarm     : one-cycle disarm request (top priority)
//   Meas_Done  : sensor result strobe; Distance valid this cycle
//   Distance   : measured distance in cm, 0 = no echo
//   Meas_Start : one-cycle measurement request
//   Sound_En   : alarm tone enable
//   Armed      : high in ARMED, ENTRY or ALARM
//   State      : current state code
module intrusion_sequencer
  import sec_pkg::*;
#(
  parameter int unsigned DIST_W      = 8,
  parameter int unsigned THRESH      = DEF_THRESH,
  parameter int unsigned HITS        = DEF_HITS,
  parameter int unsigned MEAS_PERIOD = 6000,
  parameter int unsigned EXIT_TICKS  = 20000,
  parameter int unsigned ENTRY_TICKS = 20000,
  parameter int unsigned ALARM_TICKS = 100000
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              Arm,
  input  logic              Disarm,
  input  logic              Meas_Done,
  input  logic [DIST_W-1:0] Distance,
  output logic              Meas_Start,
  output logic              Sound_En,
  output logic              Armed,
  output logic [2:0]        State
);

  // One delay counter serves all three timed states; sized for the longest.
  localparam int unsigned MAX_TICKS =
    (ALARM_TICKS > EXIT_TICKS) ?
      ((ALARM_TICKS > ENTRY_TICKS) ? ALARM_TICKS : ENTRY_TICKS) :
      ((EXIT_TICKS  > ENTRY_TICKS) ? EXIT_TICKS  : ENTRY_TICKS);
  localparam int unsigned DLY_W = $clog2(MAX_TICKS) + 1;
  localparam int unsigned HIT_W = $clog2(HITS) + 1;

  localparam logic [DLY_W-1:0] EXIT_LAST  = DLY_W'(EXIT_TICKS - 1);
  localparam logic [DLY_W-1:0] ENTRY_LAST = DLY_W'(ENTRY_TICKS - 1);
  localparam logic [DLY_W-1:0] ALARM_LAST = DLY_W'(ALARM_TICKS - 1);
  localparam logic [HIT_W-1:0] HITS_V     = HIT_W'(HITS);

  sec_state_t       state_q;
  sec_state_t       state_d;
  logic [DLY_W-1:0] dly_q;
  logic [HIT_W-1:0] hit_q;
  logic [HIT_W-1:0] hit_inc;
  logic             armed_q;
  logic             armed_d;
  logic             sound_q;
  logic             sound_d;
  logic             sched_en;
  logic             res_valid;
  logic             res_hit;

`ifdef SEC_DELAY_CHIRP_EN
  localparam int unsigned CHIRP_W = $clog2(CHIRP_HALF);
  localparam logic [CHIRP_W-1:0] CHIRP_LAST = CHIRP_W'(CHIRP_HALF - 1);
  logic [CHIRP_W-1:0] chirp_cnt_q;
`endif

  // Gating on the next state as well keeps a Disarm cycle from launching
  // one last request into DISARMED.
  assign sched_en = (state_q != ST_DISARMED) && (state_d != ST_DISARMED);

  meas_scheduler #(
    .DIST_W      (DIST_W),
    .THRESH      (THRESH),
    .MEAS_PERIOD (MEAS_PERIOD)
  ) u_sched (
    .CLK        (CLK),
    .RST        (RST),
    .en         (sched_en),
    .meas_done  (Meas_Done),
    .distance   (Distance),
    .meas_start (Meas_Start),
    .res_valid  (res_valid),
    .res_hit    (res_hit)
  );

  assign hit_inc = (hit_q >= HITS_V) ? HITS_V : hit_q + HIT_W'(1);

  // State register plus registered outputs and counters.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_DISARMED;
      dly_q   <= '0;
      hit_q   <= '0;
      armed_q <= 1'b0;
      sound_q <= 1'b0;
`ifdef SEC_DELAY_CHIRP_EN
      chirp_cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      armed_q <= armed_d;
      sound_q <= sound_d;

      // Restart on every state change; the exit condition of each timed
      // state fires on its last count, so the counter never wraps.
      if ((state_d != state_q) || (state_q == ST_DISARMED) || (state_q == ST_ARMED))
        dly_q <= '0;
      else
        dly_q <= dly_q + DLY_W'(1);

      // Hits only accumulate while ARMED; EXIT holds zero and the return
      // from ALARM starts a fresh count.
      if ((state_d == ST_DISARMED) || (state_d == ST_EXIT) ||
          ((state_q == ST_ALARM) && (state_d == ST_ARMED)))
        hit_q <= '0;
      else if ((state_q == ST_ARMED) && res_valid)
        hit_q <= res_hit ? hit_inc : '0;

`ifdef SEC_DELAY_CHIRP_EN
      if ((state_d != state_q) || !is_delay_state(state_q) ||
          (chirp_cnt_q == CHIRP_LAST))
        chirp_cnt_q <= '0;
      else
        chirp_cnt_q <= chirp_cnt_q + CHIRP_W'(1);
`endif
    end
  end

  // Next-state logic.
  // NOTE: every always_comb output gets a default first so no path
  // leaves it unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_DISARMED: if (Arm) state_d = ST_EXIT;
      ST_EXIT:     if (dly_q == EXIT_LAST) state_d = ST_ARMED;
      ST_ARMED:    if (res_valid && res_hit && (hit_inc == HITS_V)) state_d = ST_ENTRY;
      ST_ENTRY:    if (dly_q == ENTRY_LAST) state_d = ST_ALARM;
      ST_ALARM:    if (dly_q == ALARM_LAST) state_d = ST_ARMED;
      default:     state_d = ST_DISARMED;
    endcase
    if (Disarm)
      state_d = ST_DISARMED;
  end

  // Output decode, evaluated on the next state so the registered outputs
  // line up with State.
  always_comb begin
    armed_d = (state_d == ST_ARMED) || (state_d == ST_ENTRY) || (state_d == ST_ALARM);
    sound_d = (state_d == ST_ALARM);
`ifdef SEC_DELAY_CHIRP_EN
    if (is_delay_state(state_d)) begin
      if (state_d != state_q)
        sound_d = 1'b1;
      else if (chirp_cnt_q == CHIRP_LAST)
        sound_d = ~sound_q;
      else
        sound_d = sound_q;
    end
`endif
  end

  assign State    = state_q;
  assign Armed    = armed_q;
  assign Sound_En = sound_q;

endmodule

// File: tb/tb_intrusion_sequencer.sv
// Directed self-checking bench for intrusion_sequencer with shortened
// timing parameters. Expected values are hand-derived cycle counts.
module tb_intrusion_sequencer;

  localparam int unsigned DIST_W = 8;

  logic              CLK = 1'b0;
  logic              RST;
  logic              Arm;
  logic              Disarm;
  logic              Meas_Done;
  logic [DIST_W-1:0] Distance;
  logic              Meas_Start;
  logic              Sound_En;
  logic              Armed;
  logic [2:0]        State;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

`ifdef SEC_DELAY_CHIRP_EN
  localparam logic DELAY_SOUND = 1'b1;
`else
  localparam logic DELAY_SOUND = 1'b0;
`endif

  intrusion_sequencer #(
    .DIST_W      (DIST_W),
    .THRESH      (30),
    .HITS        (3),
    .MEAS_PERIOD (16),
    .EXIT_TICKS  (40),
    .ENTRY_TICKS (40),
    .ALARM_TICKS (64)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .Arm        (Arm),
    .Disarm     (Disarm),
    .Meas_Done  (Meas_Done),
    .Distance   (Distance),
    .Meas_Start (Meas_Start),
    .Sound_En   (Sound_En),
    .Armed      (Armed),
    .State      (State)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, actual, expected, cyc);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic tick_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic wait_start(output int at);
    int n;
    n = 0;
    tick();
    while (!Meas_Start && n < 40) begin
      tick();
      n++;
    end
    if (!Meas_Start) check("meas_start_wait", 0, 1);
    at = cyc;
  endtask

  task automatic done(input logic [DIST_W-1:0] d);
    Meas_Done = 1'b1;
    Distance  = d;
    tick();
    Meas_Done = 1'b0;
    Distance  = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0, te, s, ones, cnt;
    logic [DIST_W-1:0] seq [6];
    seq = '{8'd10, 8'd10, 8'd0, 8'd10, 8'd10, 8'd30};

    RST = 1'b1; Arm = 1'b0; Disarm = 1'b0; Meas_Done = 1'b0; Distance = '0;
    tick(); tick();
    check("rst_state", State, 0);
    check("rst_meas_start", Meas_Start, 0);
    check("rst_sound", Sound_En, 0);
    check("rst_armed", Armed, 0);
    RST = 1'b0;
    tick();

    // 1: arm, exit delay, periodic requests
    Arm = 1'b1; tick(); Arm = 1'b0;
    t0 = cyc;
    check("arm_state_exit", State, 1);
    check("exit_armed", Armed, 0);
    check("exit_sound", Sound_En, DELAY_SOUND);
    wait_start(s); check("exit_start1_ofs", s - t0, 16);
    done(8'd100);
    wait_start(s); check("exit_start2_ofs", s - t0, 32);
    done(8'd100);
    tick_until(t0 + 39); check("exit_last_cycle", State, 1);
    tick();               check("exit_to_armed", State, 2);
    check("armed_flag", Armed, 1);

    // 2: three hits -> entry -> alarm -> armed
    wait_start(s); done(8'd10);
    wait_start(s); done(8'd10);
    check("two_hits_still_armed", State, 2);
    wait_start(s); done(8'd10);
    check("third_hit_entry", State, 3);
    te = cyc;
    check("entry_sound", Sound_En, DELAY_SOUND);
    tick_until(te + 39); check("entry_last_cycle", State, 3);
    tick();              check("entry_to_alarm", State, 4);
    ones = 0;
    for (int i = 0; i < 64; i++) begin
      ones += int'(Sound_En);
      tick();
    end
    check("alarm_sound_cycles", ones, 64);
    check("alarm_to_armed", State, 2);
    check("post_alarm_sound", Sound_En, 0);

    // 3: broken hit runs, including Distance == THRESH
    for (int i = 0; i < 6; i++) begin
      wait_start(s);
      done(seq[i]);
      check($sformatf("seq%0d_armed", i), State, 2);
    end
    repeat (3) done(8'd10);
    check("stale_done_ignored", State, 2);

    // 4: timeout counts as a miss and suppresses one request
    wait_start(s); done(8'd10);
    wait_start(s); done(8'd10);
    check("pre_timeout_armed", State, 2);
    wait_start(s);
    cnt = 0;
    repeat (31) begin
      tick();
      cnt += int'(Meas_Start);
    end
    check("timeout_no_start", cnt, 0);
    tick();
    check("start_resumes", Meas_Start, 1);
    done(8'd10);
    check("timeout_cleared_hits", State, 2);

    // 5: disarm during alarm, with simultaneous arm
    wait_start(s); done(8'd10);
    wait_start(s); done(8'd10);
    check("reentry", State, 3);
    repeat (40) tick();
    check("realarm", State, 4);
    repeat (5) tick();
    Arm = 1'b1; Disarm = 1'b1; tick(); Arm = 1'b0; Disarm = 1'b0;
    check("disarm_state", State, 0);
    check("disarm_sound", Sound_En, 0);
    check("disarm_armed", Armed, 0);
    cnt = 0;
    repeat (40) begin
      tick();
      cnt += int'(Meas_Start);
    end
    check("disarmed_no_start", cnt, 0);
    check("disarmed_stays", State, 0);

    // 6: reset during entry
    Arm = 1'b1; tick(); Arm = 1'b0;
    t0 = cyc;
    check("rearm_exit", State, 1);
    check("rearm_sound", Sound_En, DELAY_SOUND);
    tick_until(t0 + 40);
    check("rearm_armed", State, 2);
    wait_start(s); done(8'd1);
    wait_start(s); done(8'd29);
    wait_start(s); done(8'd5);
    check("entry_again", State, 3);
    repeat (5) tick();
    RST = 1'b1; tick(); 
    check("midentry_rst_state", State, 0);
    check("midentry_rst_start", Meas_Start, 0);
    check("midentry_rst_sound", Sound_En, 0);
    check("midentry_rst_armed", Armed, 0);
    RST = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
